mem_block_arbiter: RTL and testbench
====================================

Name: mem_block_arbiter

Overview:
- Shares the single 256-bit block memory channel between the instruction cache (read-only) and the data cache (read and write-back).
- Sits between the cache fill/evict logic and the top-level block ports (iBlkRead/dBlkRead/dBlkWrite side of the simulator).
- Sequences one block transaction at a time, holds address/data stable until memory signals valid, and returns a one-cycle done pulse to the winning requester.
- Includes a starvation guard and a syscall hold.

Parameters:
- ADDR_W, 32, byte address width.
- BLK_W, 256, block width in bits (32-byte line).
- STARVE_LIMIT, 2, consecutive D-side grants allowed while an I-side request waits.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous active-high reset
- i_req  in  1  I-cache block read request; held until i_done
- i_addr  in  ADDR_W  I-cache block address
- i_done  out  1  one-cycle pulse; i_rdata valid this cycle
- i_rdata  out  BLK_W  fetched block
- d_req_rd  in  1  D-cache fill request; held until d_done
- d_req_wr  in  1  D-cache write-back request; held until d_done
- d_addr  in  ADDR_W  D-cache block address
- d_wdata  in  BLK_W  write-back block
- d_done  out  1  one-cycle pulse; read or write completed
- d_rdata  out  BLK_W  filled block (meaningful for reads only)
- sys_hold  in  1  syscall drain in progress; suppresses new I-side grants
- busy  out  1  transaction in flight (state != IDLE)
- mem_addr  out  ADDR_W  block address to memory, low 5 bits forced 0
- mem_blk_read  out  1  block read request
- mem_blk_write  out  1  block write request
- mem_wdata  out  BLK_W  block write data
- mem_rdata  in  BLK_W  block read data
- mem_rd_valid  in  1  read data valid
- mem_wr_valid  in  1  write accepted

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0: i_done, d_done, mem_blk_read, mem_blk_write, busy, mem_addr, mem_wdata, i_rdata, d_rdata. starve_cnt=0.
- States: IDLE, I_RD, D_RD, D_WR, DONE.
- IDLE arbitration, evaluated on the current cycle's inputs, winner registered at the next edge. Priority order:
  1. i_req && !sys_hold && starve_cnt==STARVE_LIMIT → I_RD
  2. d_req_wr → D_WR
  3. d_req_rd → D_RD
  4. i_req && !sys_hold → I_RD
  5. otherwise stay in IDLE.
- d_req_wr and d_req_rd both high: the write is served first (write-back before fill). The read is served in a later arbitration.
- On entering I_RD, D_RD or D_WR: latch the address (low 5 bits zeroed) into mem_addr; latch d_wdata into mem_wdata for D_WR. Assert the matching mem_blk_* from the first cycle in the state and hold it every cycle until the matching valid is sampled high.
- mem_addr and mem_wdata are stable for the whole transaction. Requester input changes mid-transaction are ignored.
- When the valid is sampled in I_RD/D_RD/D_WR:
  - Deassert mem_blk_* at that edge.
  - Capture mem_rdata into i_rdata or d_rdata (reads only).
  - Go to DONE, which pulses the corresponding *_done for exactly one cycle, then returns to IDLE.
  - DONE never arbitrates, so a requester's req drop is seen before the next grant.
- Minimum latency: request at cycle N → mem_blk_* high at N+1. If valid arrives at N+1, done pulses at N+2. The next grant can appear at the earliest at N+3.
- Valid of the wrong kind (e.g. mem_wr_valid during D_RD) is ignored. Any valid in IDLE is ignored.
- starve_cnt rules, applied at grant time:
  - Increments (saturating at STARVE_LIMIT) on each D grant while i_req is high.
  - Clears on any I grant.
  - Clears when i_req is low in IDLE.
- sys_hold blocks only new I grants. An I_RD already in flight completes normally. D traffic continues so dirty lines can be flushed.
- A requester dropping req mid-transaction does not abort: the transaction completes and done still pulses.
- Reset mid-transaction abandons the transfer; memory sees mem_blk_* drop asynchronously.
- busy = (state != IDLE).

Decomposition:
- Shared package holds:
  - the state encoding enum (IDLE/I_RD/D_RD/D_WR/DONE);
  - BLK_OFFSET_BITS=5;
  - the block-align function.
- No sub-module is needed. The arbitration priority logic may be a function within the module.

Test Plan:
- After reset with i_req=1, i_addr=0x0040_0013: mem_blk_read at cycle 1 with mem_addr=0x0040_0000. Valid at cycle 3 with mem_rdata=0xA5..A5 → i_done pulse at cycle 4, i_rdata=0xA5..A5, d_done stays 0.
- d_req_wr=1 and d_req_rd=1 together, d_addr=0x1000_0020: D_WR first (mem_blk_write=1, mem_wdata=d_wdata), d_done. The requester then drops d_req_wr, and the next arbitration issues the read.
- Starvation: i_req held, d_req_rd re-asserted continuously. Grant order is D, D, I (STARVE_LIMIT=2), then D resumes.
- sys_hold=1 with i_req=1 and d_req_wr=1: only the D write is granted, mem_blk_read never rises. Release sys_hold → I_RD on the next IDLE cycle.
- Memory delays mem_rd_valid 10 cycles and pulses mem_wr_valid during D_RD: mem_blk_read held 10 cycles, mem_addr constant, the stray write valid is ignored, d_done is a single pulse.
- Assert RESET mid-D_WR: mem_blk_write drops immediately, busy=0, no d_done. After RESET is released, a fresh request completes normally.

Source files
------------

// File: rtl/mem_block_arbiter_pkg.sv
// Shared types and helpers for the block memory arbiter.
package mem_block_arbiter_pkg;

    // Transaction sequencer states.
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StIRd  = 3'd1,
        StDRd  = 3'd2,
        StDWr  = 3'd3,
        StDone = 3'd4
    } arb_state_e;

    // A 32-byte block has 5 offset bits.
    localparam int unsigned BLK_OFFSET_BITS = 5;

    // Clears the in-block byte offset. Callers size-cast to their own address width.
    function automatic logic [63:0] block_align(input logic [63:0] addr);
        return {addr[63:BLK_OFFSET_BITS], {BLK_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/mem_block_arbiter.sv
// Shares one block memory channel between the I-cache (reads) and the D-cache
// (fills and write-backs), one transaction at a time, with a starvation guard
// for the I side and a syscall hold that blocks new I grants.
module mem_block_arbiter
    import mem_block_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned BLK_W        = 256,
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [BLK_W-1:0]  i_rdata,
    input  logic              d_req_rd,
    input  logic              d_req_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [BLK_W-1:0]  d_wdata,
    output logic              d_done,
    output logic [BLK_W-1:0]  d_rdata,
    input  logic              sys_hold,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_blk_read,
    output logic              mem_blk_write,
    output logic [BLK_W-1:0]  mem_wdata,
    input  logic [BLK_W-1:0]  mem_rdata,
    input  logic              mem_rd_valid,
    input  logic              mem_wr_valid
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    // Fixed-priority pick with the starved I request promoted to the top.
    function automatic arb_state_e arbitrate(
        input logic i_want,
        input logic hold,
        input logic starved,
        input logic d_wr,
        input logic d_rd
    );
        logic i_ok;
        i_ok = i_want && !hold;
        if (i_ok && starved) return StIRd;
        if (d_wr)            return StDWr;
        if (d_rd)            return StDRd;
        if (i_ok)            return StIRd;
        return StIdle;
    endfunction

    // Next-state and starvation counter update.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            StIdle: begin
                state_d = arbitrate(i_req, sys_hold, starve_q == STARVE_MAX, d_req_wr, d_req_rd);
                if (!i_req || state_d == StIRd) begin
                    starve_d = '0;
                end else if ((state_d == StDRd || state_d == StDWr) && starve_q != STARVE_MAX) begin
                    starve_d = starve_q + CNT_W'(1);
                end
            end
            StIRd:   if (mem_rd_valid) state_d = StDone;
            StDRd:   if (mem_rd_valid) state_d = StDone;
            StDWr:   if (mem_wr_valid) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and starvation counter registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= StIdle;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Latch address/data at grant, capture read data and raise done when valid lands.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            // Done registers are high only during the DONE cycle.
            i_done <= (state_q == StIRd) && mem_rd_valid;
            d_done <= ((state_q == StDRd) && mem_rd_valid) || ((state_q == StDWr) && mem_wr_valid);
            if (state_q == StIdle && state_d != StIdle) begin
                mem_addr <= ADDR_W'(block_align(64'((state_d == StIRd) ? i_addr : d_addr)));
                if (state_d == StDWr) begin
                    mem_wdata <= d_wdata;
                end
            end
            if (state_q == StIRd && mem_rd_valid) begin
                i_rdata <= mem_rdata;
            end
            if (state_q == StDRd && mem_rd_valid) begin
                d_rdata <= mem_rdata;
            end
        end
    end

    // Requests follow the state directly so a reset drops them asynchronously.
    always_comb begin
        busy          = (state_q != StIdle);
        mem_blk_read  = (state_q == StIRd) || (state_q == StDRd);
        mem_blk_write = (state_q == StDWr);
    end

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Directed bench for mem_block_arbiter with a transaction-level reference model
// checked every cycle, plus hand-computed expectations at key points.
module tb_mem_block_arbiter;

    localparam int STARVE_LIMIT = 2;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         i_req = 1'b0;
    logic [31:0]  i_addr = '0;
    logic         i_done;
    logic [255:0] i_rdata;
    logic         d_req_rd = 1'b0;
    logic         d_req_wr = 1'b0;
    logic [31:0]  d_addr = '0;
    logic [255:0] d_wdata = '0;
    logic         d_done;
    logic [255:0] d_rdata;
    logic         sys_hold = 1'b0;
    logic         busy;
    logic [31:0]  mem_addr;
    logic         mem_blk_read;
    logic         mem_blk_write;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_rd_valid = 1'b0;
    logic         mem_wr_valid = 1'b0;

    int    checks = 0;
    int    errors = 0;
    string done_log = "";

    mem_block_arbiter #(
        .ADDR_W(32),
        .BLK_W(256),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_done(i_done),
        .i_rdata(i_rdata),
        .d_req_rd(d_req_rd),
        .d_req_wr(d_req_wr),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_done(d_done),
        .d_rdata(d_rdata),
        .sys_hold(sys_hold),
        .busy(busy),
        .mem_addr(mem_addr),
        .mem_blk_read(mem_blk_read),
        .mem_blk_write(mem_blk_write),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_rd_valid(mem_rd_valid),
        .mem_wr_valid(mem_wr_valid)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // m_kind: 0 none, 1 I read, 2 D read, 3 D write
    int           m_kind = 0;
    bit           m_in_done = 1'b0;
    int           m_dwins = 0;
    logic [31:0]  m_addr = '0;
    logic [255:0] m_wdata = '0;
    logic [255:0] m_irdata = '0;
    logic [255:0] m_drdata = '0;
    bit           m_idone = 1'b0;
    bit           m_ddone = 1'b0;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_kind = 0; m_in_done = 0; m_dwins = 0;
            m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
            m_idone = 0; m_ddone = 0;
        end else begin : step
            int pick;
            bit i_ok;
            m_idone = 0;
            m_ddone = 0;
            if (m_in_done) begin
                m_in_done = 0;
            end else if (m_kind != 0) begin
                if ((m_kind == 3 && mem_wr_valid) || (m_kind != 3 && mem_rd_valid)) begin
                    if (m_kind == 1) begin
                        m_idone = 1; m_irdata = mem_rdata;
                    end else begin
                        m_ddone = 1;
                        if (m_kind == 2) m_drdata = mem_rdata;
                    end
                    m_kind = 0;
                    m_in_done = 1;
                end
            end else begin
                i_ok = i_req && !sys_hold;
                pick = 0;
                if (i_ok && m_dwins == STARVE_LIMIT) pick = 1;
                else if (d_req_wr) pick = 3;
                else if (d_req_rd) pick = 2;
                else if (i_ok) pick = 1;
                if (!i_req || pick == 1) m_dwins = 0;
                else if (pick >= 2 && m_dwins < STARVE_LIMIT) m_dwins++;
                if (pick != 0) begin
                    m_kind = pick;
                    m_addr = ((pick == 1) ? i_addr : d_addr) & 32'hFFFF_FFE0;
                    if (pick == 3) m_wdata = d_wdata;
                end
            end
        end
    end

    // Per-cycle comparison against the model, after the DUT has settled.
    always @(posedge CLK) begin
        #2;
        if (!RESET) begin
            check("busy", 256'(busy), 256'(m_kind != 0 || m_in_done));
            check("mem_blk_read", 256'(mem_blk_read), 256'(m_kind == 1 || m_kind == 2));
            check("mem_blk_write", 256'(mem_blk_write), 256'(m_kind == 3));
            check("mem_addr", 256'(mem_addr), 256'(m_addr));
            check("mem_wdata", mem_wdata, m_wdata);
            check("i_done", 256'(i_done), 256'(m_idone));
            check("d_done", 256'(d_done), 256'(m_ddone));
            check("i_rdata", i_rdata, m_irdata);
            check("d_rdata", d_rdata, m_drdata);
            if (i_done) done_log = {done_log, "I"};
            if (d_done) done_log = {done_log, "D"};
        end
    end

    // Memory responder: waits (bounded) for the request, delays, pulses valid one cycle.
    // Returns on the negedge of the DONE cycle.
    task automatic serve(input bit is_wr, input int delay, input logic [255:0] rdata);
        int n;
        n = 0;
        while (!(is_wr ? mem_blk_write : mem_blk_read) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) begin
            check("serve_request_seen", 256'(0), 256'(1));
            return;
        end
        repeat (delay) @(negedge CLK);
        if (is_wr) mem_wr_valid = 1'b1;
        else begin
            mem_rd_valid = 1'b1;
            mem_rdata = rdata;
        end
        @(negedge CLK);
        mem_rd_valid = 1'b0;
        mem_wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [255:0] pat_a5, pat_wb, pat_rd;

    initial begin
        pat_a5 = {8{32'hA5A5_A5A5}};
        pat_wb = {8{32'hDEAD_BEEF}};
        pat_rd = {8{32'h1234_5678}};

        // Reset values.
        repeat (3) @(negedge CLK);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_rd", 256'(mem_blk_read), 256'(0));
        check("rst_wr", 256'(mem_blk_write), 256'(0));
        check("rst_done", 256'({i_done, d_done}), 256'(0));
        check("rst_addr", 256'(mem_addr), 256'(0));
        check("rst_data", mem_wdata | i_rdata | d_rdata, 256'(0));

        // I fetch with valid two cycles after the request rises.
        RESET = 1'b0;
        i_req = 1'b1;
        i_addr = 32'h0040_0013;
        @(negedge CLK);
        check("t1_rd_c1", 256'(mem_blk_read), 256'(1));
        check("t1_addr", 256'(mem_addr), 256'(32'h0040_0000));
        @(negedge CLK);
        @(negedge CLK);
        mem_rd_valid = 1'b1;
        mem_rdata = pat_a5;
        @(negedge CLK);
        mem_rd_valid = 1'b0;
        check("t1_i_done", 256'(i_done), 256'(1));
        check("t1_i_rdata", i_rdata, pat_a5);
        check("t1_d_done", 256'(d_done), 256'(0));
        i_req = 1'b0;
        @(negedge CLK);
        check("t1_idle", 256'({busy, i_done}), 256'(0));

        // Write-back beats fill when both are requested.
        d_req_wr = 1'b1;
        d_req_rd = 1'b1;
        d_addr = 32'h1000_0020;
        d_wdata = pat_wb;
        serve(1'b1, 0, '0);
        check("t2_wr_done", 256'(d_done), 256'(1));
        check("t2_wr_addr", 256'(mem_addr), 256'(32'h1000_0020));
        check("t2_wr_data", mem_wdata, pat_wb);
        d_req_wr = 1'b0;
        serve(1'b0, 0, pat_rd);
        check("t2_rd_done", 256'(d_done), 256'(1));
        check("t2_rd_data", d_rdata, pat_rd);
        d_req_rd = 1'b0;

        // Starvation guard: D, D, I, then D again.
        done_log = "";
        i_req = 1'b1;
        i_addr = 32'h0000_1000;
        d_req_rd = 1'b1;
        d_addr = 32'h2000_0040;
        for (int k = 0; k < 4; k++) begin
            serve(1'b0, 0, 256'(k + 1));
        end
        check_str("t3_order", done_log, "DDID");
        i_req = 1'b0;
        d_req_rd = 1'b0;
        @(negedge CLK);

        // Syscall hold blocks I but lets the write-back through.
        sys_hold = 1'b1;
        i_req = 1'b1;
        i_addr = 32'h0000_2000;
        d_req_wr = 1'b1;
        d_addr = 32'h3000_0000;
        serve(1'b1, 1, '0);
        check("t4_wr_done", 256'(d_done), 256'(1));
        d_req_wr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("t4_no_iread", 256'({mem_blk_read, busy}), 256'(0));
        end
        sys_hold = 1'b0;
        @(negedge CLK);
        check("t4_iread", 256'(mem_blk_read), 256'(1));
        check("t4_iaddr", 256'(mem_addr), 256'(32'h0000_2000));
        serve(1'b0, 1, pat_a5);
        check("t4_i_done", 256'(i_done), 256'(1));
        i_req = 1'b0;

        // Slow read with a stray write valid in the middle.
        d_req_rd = 1'b1;
        d_addr = 32'h4000_0013;
        begin : slow_rd
            int n;
            n = 0;
            while (!mem_blk_read && n < 20) begin
                @(negedge CLK);
                n++;
            end
        end
        for (int k = 0; k < 10; k++) begin
            check("t5_rd_held", 256'(mem_blk_read), 256'(1));
            check("t5_addr", 256'(mem_addr), 256'(32'h4000_0000));
            mem_wr_valid = (k == 3);
            @(negedge CLK);
        end
        mem_wr_valid = 1'b0;
        mem_rd_valid = 1'b1;
        mem_rdata = pat_wb;
        @(negedge CLK);
        mem_rd_valid = 1'b0;
        check("t5_d_done", 256'(d_done), 256'(1));
        check("t5_d_rdata", d_rdata, pat_wb);
        d_req_rd = 1'b0;
        @(negedge CLK);
        check("t5_single_pulse", 256'(d_done), 256'(0));

        // Reset in the middle of a write-back.
        d_req_wr = 1'b1;
        d_addr = 32'h5000_0000;
        begin : wait_wr
            int n;
            n = 0;
            while (!mem_blk_write && n < 20) begin
                @(negedge CLK);
                n++;
            end
        end
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("t6_wr_drop", 256'(mem_blk_write), 256'(0));
        check("t6_busy", 256'(busy), 256'(0));
        check("t6_no_done", 256'(d_done), 256'(0));
        d_req_wr = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        i_req = 1'b1;
        i_addr = 32'h6000_0044;
        serve(1'b0, 2, pat_rd);
        check("t6_i_done", 256'(i_done), 256'(1));
        check("t6_i_rdata", i_rdata, pat_rd);
        check("t6_i_addr", 256'(mem_addr), 256'(32'h6000_0040));
        i_req = 1'b0;
        repeat (3) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
